// File: rtl/crc_engine.sv
// Bit-serial CRC generator/checker with programmable width, polynomial,
// seed and frame length; direct LFSR form, gap-tolerant via din_valid.
module crc_engine #(
    parameter int               CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599,
    parameter logic [CRC_W-1:0] INIT  = '0,
    parameter int               LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             mode,
    input  logic             abort,
    input  logic             din_valid,
    input  logic             din,
    output logic             busy,
    output logic             done,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_ok
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [LEN_W:0] ONE   = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] CRC_L = (LEN_W+1)'(CRC_W);

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W:0]   total_q, total_d;
    logic             mode_q, mode_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             crc_ok_q, crc_ok_d;
    logic             done_q, done_d;

    logic [LEN_W:0]   total_w;
    logic [LEN_W:0]   cnt_nx;
    logic [CRC_W-1:0] crc_nx;
    logic             fb;

    // One extra bit so len + CRC_W cannot wrap at the maximum len.
    assign total_w = mode ? ({1'b0, len} + CRC_L) : {1'b0, len};
    assign cnt_nx  = cnt_q + ONE;
    assign fb      = din ^ crc_q[CRC_W-1];
    assign crc_nx  = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        mode_d    = mode_q;
        crc_out_d = crc_out_q;
        crc_ok_d  = crc_ok_q;
        done_d    = 1'b0;
        if (start) begin
            crc_d   = INIT;
            cnt_d   = '0;
            total_d = total_w;
            mode_d  = mode;
            if (total_w == '0) begin
                state_d   = IDLE;
                done_d    = 1'b1;
                crc_out_d = INIT;
                crc_ok_d  = 1'b0;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (abort) begin
                state_d = IDLE;
            end else if (din_valid) begin
                crc_d = crc_nx;
                cnt_d = cnt_nx;
                if (cnt_nx == total_q) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    crc_out_d = crc_nx;
                    crc_ok_d  = mode_q && (crc_nx == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= '0;
            cnt_q     <= '0;
            total_q   <= '0;
            mode_q    <= 1'b0;
            crc_out_q <= '0;
            crc_ok_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            mode_q    <= mode_d;
            crc_out_q <= crc_out_d;
            crc_ok_q  <= crc_ok_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign crc_out = crc_out_q;
    assign crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed-vector bench for crc_engine: CAN-default instance plus a
// CRC-8 (poly 0x07) instance sharing clock and reset.
module tb_crc_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        busy;
    logic        done;
    logic [14:0] crc_out;
    logic        crc_ok;

    logic        s8 = 1'b0;
    logic [15:0] len8 = '0;
    logic        dv8 = 1'b0;
    logic        d8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [7:0]  crc8;
    logic        ok8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    crc_engine u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .mode(mode), .abort(abort), .din_valid(din_valid), .din(din),
        .busy(busy), .done(done), .crc_out(crc_out), .crc_ok(crc_ok)
    );

    crc_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .LEN_W(16)) u_crc8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .len(len8),
        .mode(1'b0), .abort(1'b0), .din_valid(dv8), .din(d8),
        .busy(busy8), .done(done8), .crc_out(crc8), .crc_ok(ok8)
    );

    // Stimulus drivers; callers are always positioned at a falling edge.
    task automatic pulse_start(input logic [15:0] l, input logic m);
        start = 1'b1; len = l; mode = m; din_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        din_valid = 1'b1; din = b;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy got %b exp 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL reset_done got %b exp 0", done);
        end
        vectors++;
        if (crc_out !== 15'h0) begin
            miscompares++; $display("FAIL reset_crc got %h exp 0000", crc_out);
        end
        vectors++;
        if (crc_ok !== 1'b0) begin
            miscompares++; $display("FAIL reset_ok got %b exp 0", crc_ok);
        end
    endtask

    task automatic test_gen_len1;
        pulse_start(16'd1, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL g1_busy got %b exp 1", busy);
        end
        send_bit(1'b1);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL g1_done got done=%b busy=%b exp 1/0", done, busy);
        end
        vectors++;
        if (crc_out !== 15'h4599 || crc_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL g1_crc got %h/%b exp 4599/0", crc_out, crc_ok);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || crc_out !== 15'h4599) begin
            miscompares++;
            $display("FAIL g1_hold got done=%b crc=%h exp 0/4599", done, crc_out);
        end
    endtask

    task automatic test_gen_len2;
        pulse_start(16'd2, 1'b0);
        send_bit(1'b1);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL g2_early got done=%b exp 0", done);
        end
        send_bit(1'b0);
        vectors++;
        if (done !== 1'b1 || crc_out !== 15'h4EAB) begin
            miscompares++;
            $display("FAIL g2_crc got done=%b crc=%h exp 1/4eab", done, crc_out);
        end
    endtask

    task automatic test_check;
        logic [14:0] c;
        for (int pass = 0; pass < 2; pass++) begin
            c = 15'h4599;
            if (pass == 1) c[0] = ~c[0];
            pulse_start(16'd1, 1'b1);
            send_bit(1'b1);
            for (int i = 14; i >= 1; i--) send_bit(c[i]);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL chk_early p%0d got done=%b busy=%b exp 0/1",
                         pass, done, busy);
            end
            send_bit(c[0]);
            vectors++;
            if (done !== 1'b1) begin
                miscompares++; $display("FAIL chk_done p%0d got %b exp 1", pass, done);
            end
            if (pass == 0) begin
                vectors++;
                if (crc_out !== 15'h0 || crc_ok !== 1'b1) begin
                    miscompares++;
                    $display("FAIL chk_good got %h/%b exp 0000/1", crc_out, crc_ok);
                end
            end else begin
                vectors++;
                if (crc_out !== 15'h4599 || crc_ok !== 1'b0) begin
                    miscompares++;
                    $display("FAIL chk_bad got %h/%b exp 4599/0", crc_out, crc_ok);
                end
            end
        end
    endtask

    task automatic test_gap;
        pulse_start(16'd2, 1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_busy c%0d got busy=%b done=%b exp 1/0",
                         i, busy, done);
            end
        end
        send_bit(1'b0);
        vectors++;
        if (done !== 1'b1 || crc_out !== 15'h4EAB) begin
            miscompares++;
            $display("FAIL gap_crc got done=%b crc=%h exp 1/4eab", done, crc_out);
        end
    endtask

    task automatic test_len0;
        @(negedge clk);
        start = 1'b1; len = 16'd0; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_done got done=%b busy=%b exp 1/0", done, busy);
        end
        vectors++;
        if (crc_out !== 15'h0 || crc_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_crc got %h/%b exp 0000/0", crc_out, crc_ok);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_after got busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_abort;
        pulse_start(16'd1, 1'b0);
        send_bit(1'b1);
        pulse_start(16'd2, 1'b0);
        send_bit(1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state got busy=%b done=%b exp 0/0", busy, done);
        end
        send_bit(1'b0);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || crc_out !== 15'h4599) begin
            miscompares++;
            $display("FAIL abort_hold got done=%b crc=%h exp 0/4599", done, crc_out);
        end
    endtask

    task automatic test_restart;
        pulse_start(16'd2, 1'b0);
        send_bit(1'b1);
        abort = 1'b1;
        pulse_start(16'd1, 1'b0);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_state got busy=%b done=%b exp 1/0", busy, done);
        end
        send_bit(1'b1);
        vectors++;
        if (done !== 1'b1 || crc_out !== 15'h4599) begin
            miscompares++;
            $display("FAIL restart_crc got done=%b crc=%h exp 1/4599", done, crc_out);
        end
    endtask

    task automatic test_back_to_back;
        pulse_start(16'd1, 1'b0);
        send_bit(1'b0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || crc_out !== 15'h0) begin
            miscompares++;
            $display("FAIL b2b_first got done=%b busy=%b crc=%h exp 1/0/0000",
                     done, busy, crc_out);
        end
        pulse_start(16'd2, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_busy got %b exp 1", busy);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        vectors++;
        if (done !== 1'b1 || crc_out !== 15'h4EAB) begin
            miscompares++;
            $display("FAIL b2b_second got done=%b crc=%h exp 1/4eab", done, crc_out);
        end
    endtask

    task automatic test_mid_reset;
        pulse_start(16'd2, 1'b0);
        send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || crc_out !== 15'h0 || crc_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_out got busy=%b done=%b crc=%h ok=%b exp 0/0/0000/0",
                     busy, done, crc_out, crc_ok);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_nodone got done=%b busy=%b exp 0/0", done, busy);
        end
        pulse_start(16'd1, 1'b0);
        send_bit(1'b1);
        vectors++;
        if (done !== 1'b1 || crc_out !== 15'h4599) begin
            miscompares++;
            $display("FAIL mrst_frame got done=%b crc=%h exp 1/4599", done, crc_out);
        end
    endtask

    task automatic test_crc8;
        logic [7:0] b;
        b = 8'h01;
        s8 = 1'b1; len8 = 16'd8;
        @(negedge clk);
        s8 = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            dv8 = 1'b1; d8 = b[i];
            @(negedge clk);
        end
        dv8 = 1'b0;
        vectors++;
        if (done8 !== 1'b1 || crc8 !== 8'h07 || ok8 !== 1'b0) begin
            miscompares++;
            $display("FAIL crc8 got done=%b crc=%h ok=%b exp 1/07/0", done8, crc8, ok8);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_gen_len1;
        test_gen_len2;
        test_check;
        test_gap;
        test_len0;
        test_abort;
        test_restart;
        test_back_to_back;
        test_mid_reset;
        test_crc8;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised serial CRC generator/checker for the CAN controller datapath, and the successor to the fixed 15-bit CRC block. It computes a CRC of configurable width, polynomial and seed over a bit-serial frame of programmable length. It accepts bits only on a valid strobe, so bit-stuffing gaps are tolerated. A check mode lets the receive path verify an incoming frame plus its appended CRC in one pass. The engine uses the direct (non-augmented) LFSR form: no trailing zero bits are needed.

## Interface
- CRC_W, 15, CRC width in bits (2..32)
- POLY, 15'h4599, generator polynomial without the implicit x^CRC_W term (CAN: x^15+x^14+x^10+x^8+x^7+x^4+x^3+1)
- INIT, 0, register seed loaded at frame start
- LEN_W, 16, width of the frame-length field
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a frame; samples len and mode
- len  in  LEN_W  number of payload bits in the frame
- mode  in  1  0 = generate, 1 = check (payload followed by CRC_W received CRC bits)
- abort  in  1  synchronous abort of the current frame
- din_valid  in  1  din is valid this cycle
- din  in  1  serial data, MSB-first
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse when a frame completes
- crc_out  out  CRC_W  final CRC register value; held until the next start
- crc_ok  out  1  check mode only: final register == 0; held with crc_out

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE→RUN on start:
  - crc ← INIT, cnt ← 0.
  - Latch len and mode.
  - total ← len (generate) or len+CRC_W (check).
  - Compute total at LEN_W+1 bits, so there is no overflow at len = 2^LEN_W−1.
- start with total==0 (generate mode, len=0): stay in IDLE; next cycle done=1, crc_out=INIT, crc_ok=0.
- In RUN, each cycle with din_valid=1:
  - fb = din ^ crc[CRC_W−1].
  - crc ← {crc[CRC_W−2:0],0} ^ (fb ? POLY : 0).
  - cnt ← cnt+1.
- din_valid=0: crc and cnt hold (stuff-bit gap); there is no limit on gap length.
- The accepted bit where cnt == total−1 is the last bit:
  - Next state is IDLE.
  - crc_out ← updated crc.
  - crc_ok ← (mode==1 && updated crc==0).
  - done=1 for one cycle.
- din_valid in IDLE is ignored.
- start while in RUN restarts the frame: reload INIT, new len/mode; no done is issued for the abandoned frame.
- abort in RUN: go to IDLE with no done; crc_out and crc_ok keep their previous values.
- abort and start in the same cycle: start wins.
- abort in IDLE: no effect.
- crc_out and crc_ok change only at frame completion or reset.

## Timing
- Reset values: busy=0, done=0, crc_out=0, crc_ok=0; state IDLE; internal crc=0, cnt=0.
- start is sampled on the edge where it is high; busy is high from the next cycle.
- A din_valid bit may be accepted in the cycle immediately after start.
- Latency: done is asserted on the clock edge after the last accepted bit's edge, i.e. the cycle following the last valid bit.
- crc_out and crc_ok are valid in the same cycle as done.
- busy falls in the same cycle done rises.
- Back-to-back frames: start may be asserted in the done cycle, and busy stays 0 for only that cycle.
- Throughput: 1 bit per clock when din_valid is continuously high.
- Reset asserted mid-frame immediately forces every output to its reset value; no done is issued.

## Test plan
- Generate with CAN defaults, len=1, din=1 -> done one cycle after the bit, crc_out=15'h4599, crc_ok=0.
- Generate, len=2, bits 1,0 -> crc_out=15'h4EAB.
- Check mode, len=1, payload 1 then the 15 bits of 15'h4599 MSB-first (16 accepted bits) -> done, crc_out=0, crc_ok=1. Flip one CRC bit -> crc_ok=0, crc_out≠0.
- Repeat the len=2 vector with din_valid low for 3 cycles between the bits -> identical crc_out=15'h4EAB; busy high throughout the gap.
- Boundary cases:
  - len=0, generate -> done the next cycle, crc_out=INIT, busy never rises.
  - abort after 1 of 2 bits -> no done; crc_out keeps the previous frame's value.
  - start mid-frame -> only the new frame's done appears.
- Reset asserted mid-frame -> busy/done/crc_out/crc_ok all 0 immediately. A following len=1, din=1 frame -> crc_out=15'h4599.
- Parametrised instance CRC_W=8, POLY=8'h07, INIT=0, len=8, byte 8'h01 MSB-first -> crc_out=8'h07.
